ccd_pixel_packer: RTL and testbench



---
 rtl/ccd_pixel_packer.sv | 197 +++++++++++++++++++
 tb/tb_ccd_pixel_packer.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccd_pixel_packer.sv
// Purpose: frames the CCD pixel stream as sync/ID header plus MSB/LSB byte pairs for the TX FIFO.
// Latency: first header byte offered the cycle after the first pixel is accepted; 2 cycles/pixel sustained.
// Backpressure: tx_wfull freezes state and tx_wdata; pix_ready drops while a held pixel is still being written.
// Build option: define PACK_CHECKSUM_EN to append a mod-256 checksum trailer to every complete frame.
module ccd_pixel_packer #(
    parameter int         PIX_WIDTH = 16,
    parameter logic [7:0] SYNC0     = 8'hA5,
    parameter logic [7:0] SYNC1     = 8'h5A
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PIX_WIDTH-1:0] pix_data,
    input  logic                 pix_valid,
    input  logic                 pix_first,
    input  logic                 pix_last,
    output logic                 pix_ready,
    output logic [7:0]           tx_wdata,
    output logic                 tx_winc,
    input  logic                 tx_wfull,
    output logic [7:0]           frame_id,
    output logic                 busy,
    output logic                 err_sticky
);

`ifdef PACK_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_HDR0, ST_HDR1, ST_HID, ST_PHI, ST_PLO, ST_WAIT, ST_CSUM
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_HDR0, ST_HDR1, ST_HID, ST_PHI, ST_PLO, ST_WAIT
    } state_t;
`endif

    state_t      state, state_nxt;
    logic [15:0] hold_q, hold_nxt;
    logic        last_q, last_nxt;
    logic [7:0]  wdata_nxt;
    logic [7:0]  fid_nxt;
    logic        err_nxt;
    logic        emit;
    logic        take;
    logic [15:0] pix_ext;
`ifdef PACK_CHECKSUM_EN
    logic [7:0]  acc_q, acc_nxt;
`endif

    // Zero-extend the sample to the 16-bit word carried on the wire.
    always_comb begin
        pix_ext                = '0;
        pix_ext[PIX_WIDTH-1:0] = pix_data;
    end

    // A byte is written only from an emitting state and only when the FIFO has room.
    assign tx_winc = emit & ~tx_wfull;
    assign busy    = (state != ST_IDLE);

    // Next-state, handshake and next-byte decode; tx_wdata is preloaded with the byte the next state emits.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_q;
        last_nxt  = last_q;
        wdata_nxt = tx_wdata;
        fid_nxt   = frame_id;
        err_nxt   = err_sticky;
        emit      = 1'b0;
        pix_ready = 1'b0;
        take      = 1'b0;
`ifdef PACK_CHECKSUM_EN
        acc_nxt   = acc_q;
`endif
        case (state)
            ST_IDLE: begin
                pix_ready = 1'b1;
                if (pix_valid) begin
                    if (pix_first) take = 1'b1;
                    else           err_nxt = 1'b1;
                end
            end
            ST_HDR0: begin
                emit = 1'b1;
                if (!tx_wfull) begin
                    wdata_nxt = SYNC1;
                    state_nxt = ST_HDR1;
                end
            end
            ST_HDR1: begin
                emit = 1'b1;
                if (!tx_wfull) begin
                    wdata_nxt = frame_id;
                    state_nxt = ST_HID;
                end
            end
            ST_HID: begin
                emit = 1'b1;
                if (!tx_wfull) begin
                    wdata_nxt = hold_q[15:8];
                    state_nxt = ST_PHI;
`ifdef PACK_CHECKSUM_EN
                    acc_nxt   = acc_q + tx_wdata;
`endif
                end
            end
            ST_PHI: begin
                emit = 1'b1;
                if (!tx_wfull) begin
                    wdata_nxt = hold_q[7:0];
                    state_nxt = ST_PLO;
`ifdef PACK_CHECKSUM_EN
                    acc_nxt   = acc_q + tx_wdata;
`endif
                end
            end
            ST_PLO: begin
                emit      = 1'b1;
                // Overlapping the next accept with this write gives the 2-cycle pixel cadence.
                pix_ready = !last_q && !tx_wfull;
                if (!tx_wfull) begin
`ifdef PACK_CHECKSUM_EN
                    acc_nxt = acc_q + tx_wdata;
`endif
                    if (last_q) begin
                        fid_nxt = frame_id + 8'd1;
`ifdef PACK_CHECKSUM_EN
                        wdata_nxt = acc_q + tx_wdata;
                        state_nxt = ST_CSUM;
`else
                        state_nxt = ST_IDLE;
`endif
                    end else if (pix_valid) begin
                        take = 1'b1;
                    end else begin
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                pix_ready = 1'b1;
                if (pix_valid) take = 1'b1;
            end
`ifdef PACK_CHECKSUM_EN
            ST_CSUM: begin
                emit = 1'b1;
                if (!tx_wfull) state_nxt = ST_IDLE;
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase

        // A new pixel either starts a frame or continues the current one.
        if (take) begin
            hold_nxt = pix_ext;
            last_nxt = pix_last;
            if (pix_first) begin
                // A first flag inside an open frame truncates it and moves on to the next ID.
                if (state != ST_IDLE) begin
                    err_nxt = 1'b1;
                    fid_nxt = frame_id + 8'd1;
                end
                wdata_nxt = SYNC0;
                state_nxt = ST_HDR0;
`ifdef PACK_CHECKSUM_EN
                acc_nxt   = '0;
`endif
            end else begin
                wdata_nxt = pix_ext[15:8];
                state_nxt = ST_PHI;
            end
        end
    end

    // State and datapath registers; reset drops any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            hold_q     <= '0;
            last_q     <= 1'b0;
            tx_wdata   <= '0;
            frame_id   <= '0;
            err_sticky <= 1'b0;
`ifdef PACK_CHECKSUM_EN
            acc_q      <= '0;
`endif
        end else begin
            state      <= state_nxt;
            hold_q     <= hold_nxt;
            last_q     <= last_nxt;
            tx_wdata   <= wdata_nxt;
            frame_id   <= fid_nxt;
            err_sticky <= err_nxt;
`ifdef PACK_CHECKSUM_EN
            acc_q      <= acc_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_ccd_pixel_packer.sv
// Bench for ccd_pixel_packer: directed vector table, FIFO-full stall, 12-bit instance,
// frame_id wrap, mid-frame reset and a randomized run against a frame-level model.
// Trailer bytes are expected only when PACK_CHECKSUM_EN is defined.
module tb_ccd_pixel_packer;

`ifdef PACK_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] pix_data;
    logic [11:0] pix_data12;
    logic        pix_valid, pix_first, pix_last;
    logic        pix_ready, pix_ready12;
    logic [7:0]  tx_wdata, tx_wdata12;
    logic        tx_winc, tx_winc12;
    logic        tx_wfull;
    logic [7:0]  frame_id, frame_id12;
    logic        busy, busy12, err_sticky, err_sticky12;
    logic        full_force, rnd_en, rnd_bit;

    assign pix_data12 = pix_data[11:0];
    assign tx_wfull   = full_force | (rnd_en & rnd_bit);

    always #5 clk = ~clk;

    ccd_pixel_packer dut (
        .clk(clk), .rst_n(rst_n), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_first(pix_first), .pix_last(pix_last), .pix_ready(pix_ready),
        .tx_wdata(tx_wdata), .tx_winc(tx_winc), .tx_wfull(tx_wfull),
        .frame_id(frame_id), .busy(busy), .err_sticky(err_sticky)
    );

    ccd_pixel_packer #(.PIX_WIDTH(12)) dut12 (
        .clk(clk), .rst_n(rst_n), .pix_data(pix_data12), .pix_valid(pix_valid),
        .pix_first(pix_first), .pix_last(pix_last), .pix_ready(pix_ready12),
        .tx_wdata(tx_wdata12), .tx_winc(tx_winc12), .tx_wfull(tx_wfull),
        .frame_id(frame_id12), .busy(busy12), .err_sticky(err_sticky12)
    );

    typedef struct packed { logic [15:0] d; logic f; logic l; } pix_t;
    typedef struct {
        int              npix;
        logic [0:3][15:0] pix;
        logic [0:3]       first;
        logic [0:3]       last;
        logic [7:0]       fid;
        logic             err;
    } vec_t;

    int          checks = 0, errors = 0;
    int          viol_full = 0;
    int          cyc = 0;
    int          last_acc_cyc = 0;
    logic [7:0]  got_q[$], got12_q[$], exp_q[$];
    pix_t        sent_q[$];
    logic [7:0]  m_fid;
    logic        m_err;
    vec_t        tv[4];
    string       tv_exp[4];

    // Random full pattern, gated by rnd_en.
    initial begin
        rnd_bit = 1'b0;
        forever begin
            @(posedge clk);
            #1 rnd_bit = ($urandom_range(0, 2) == 0);
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Byte capture: a write happens at the posedge following a negedge that shows tx_winc=1.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_winc)   got_q.push_back(tx_wdata);
            if (tx_winc12) got12_q.push_back(tx_wdata12);
            if (tx_wfull && (tx_winc || tx_winc12)) viol_full++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_pix(input logic [15:0] d, input logic f, input logic l);
        int n;
        bit done;
        pix_data = d; pix_first = f; pix_last = l; pix_valid = 1'b1;
        n = 0; done = 0;
        while (!done) begin
            @(negedge clk);
            if (pix_ready) done = 1;
            else begin
                n++;
                if (n > 200) begin
                    chk("accept_timeout", 32'(pix_ready), 1);
                    pix_valid = 1'b0;
                    return;
                end
            end
        end
        @(posedge clk);
        last_acc_cyc = cyc;
        sent_q.push_back(pix_t'({d, f, l}));
        #1 pix_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(busy), 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0; pix_valid = 1'b0; pix_first = 1'b0; pix_last = 1'b0;
        pix_data = '0; full_force = 1'b0; rnd_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        sent_q.delete();
    endtask

    // Tokens are 3 chars: ' ' + hex byte, or '+' + hex byte for a checksum trailer.
    task automatic load_exp(input string s);
        logic [7:0] b;
        exp_q.delete();
        for (int i = 0; i + 2 < s.len(); i += 3) begin
            b = 8'(s.substr(i + 1, i + 2).atohex());
            if (s[i] != 8'h2B || CSUM_EN) exp_q.push_back(b);
        end
    endtask

    // Frame-level reference: walks the accepted pixels and applies the framing rules.
    task automatic run_model();
        bit         in_frame;
        logic [7:0] sum;
        pix_t       p;
        in_frame = 0; sum = '0;
        exp_q.delete(); m_fid = '0; m_err = 1'b0;
        foreach (sent_q[i]) begin
            p = sent_q[i];
            if (!in_frame && !p.f) begin
                m_err = 1'b1;
                continue;
            end
            if (p.f) begin
                if (in_frame) begin
                    m_err = 1'b1;
                    m_fid++;
                end
                exp_q.push_back(8'hA5); exp_q.push_back(8'h5A); exp_q.push_back(m_fid);
                sum = m_fid;
                in_frame = 1;
            end
            exp_q.push_back(p.d[15:8]);
            exp_q.push_back(p.d[7:0]);
            sum = sum + p.d[15:8] + p.d[7:0];
            if (p.l) begin
                if (CSUM_EN) exp_q.push_back(sum);
                m_fid++;
                in_frame = 0;
            end
        end
    endtask

    task automatic cmp_stream(input string name, input bit use12, input int base);
        int n;
        n = (use12 ? got12_q.size() : got_q.size()) - base;
        chk({name, "_count"}, 32'(n), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < n; i++)
            chk($sformatf("%s_byte%0d", name, i),
                32'(use12 ? got12_q[base + i] : got_q[base + i]), 32'(exp_q[i]));
    endtask

    initial begin
        int base;
        int acc_cyc[4];

        rst_n = 1'b0; pix_valid = 1'b0; pix_first = 1'b0; pix_last = 1'b0;
        pix_data = '0; full_force = 1'b0; rnd_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_winc", 32'(tx_winc), 0);
        chk("rst_wdata", 32'(tx_wdata), 0);
        chk("rst_frame_id", 32'(frame_id), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err_sticky), 0);
        chk("rst_frame_id12", 32'(frame_id12), 0);
        rst_n = 1'b1;

        // Directed vectors: pixels, flags, expected byte stream, final frame_id and err_sticky.
        tv[0] = '{3, {16'h0123, 16'h4567, 16'h89AB, 16'h0000}, 4'b1000, 4'b0010, 8'd1, 1'b0};
        tv_exp[0] = " A5 5A 00 01 23 45 67 89 AB+04";
        tv[1] = '{1, {16'h1234, 16'h0000, 16'h0000, 16'h0000}, 4'b1000, 4'b1000, 8'd1, 1'b0};
        tv_exp[1] = " A5 5A 00 12 34+46";
        tv[2] = '{2, {16'h7777, 16'hBEEF, 16'h0000, 16'h0000}, 4'b0100, 4'b0100, 8'd1, 1'b1};
        tv_exp[2] = " A5 5A 00 BE EF+AD";
        tv[3] = '{4, {16'h1111, 16'h2222, 16'h3333, 16'h4444}, 4'b1010, 4'b0001, 8'd2, 1'b1};
        tv_exp[3] = " A5 5A 00 11 11 22 22 A5 5A 01 33 33 44 44+EF";

        for (int v = 0; v < 4; v++) begin
            do_reset();
            base = got_q.size();
            for (int i = 0; i < tv[v].npix; i++) begin
                send_pix(tv[v].pix[i], tv[v].first[i], tv[v].last[i]);
                acc_cyc[i] = last_acc_cyc;
            end
            wait_idle($sformatf("v%0d_idle", v));
            load_exp(tv_exp[v]);
            cmp_stream($sformatf("v%0d", v), 1'b0, base);
            chk($sformatf("v%0d_frame_id", v), 32'(frame_id), 32'(tv[v].fid));
            chk($sformatf("v%0d_err", v), 32'(err_sticky), 32'(tv[v].err));
            if (v == 0) chk("v0_pix_spacing", 32'(acc_cyc[2] - acc_cyc[1]), 2);
        end

        // Stray non-first pixel in IDLE: no bytes, sticky error, next frame still packs.
        do_reset();
        base = got_q.size();
        send_pix(16'h5555, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("stray_bytes", 32'(got_q.size() - base), 0);
        chk("stray_err", 32'(err_sticky), 1);
        chk("stray_busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        send_pix(16'h0A0B, 1'b1, 1'b1);
        wait_idle("stray_idle");
        load_exp(" A5 5A 00 0A 0B+15");
        cmp_stream("stray_next", 1'b0, base);

        // 12-bit instance: single full-scale pixel.
        do_reset();
        base = got12_q.size();
        send_pix(16'h0FFF, 1'b1, 1'b1);
        wait_idle("w12_idle");
        load_exp(" A5 5A 00 0F FF+0E");
        cmp_stream("w12", 1'b1, base);
        chk("w12_frame_id", 32'(frame_id12), 1);
        chk("w12_err", 32'(err_sticky12), 0);
        chk("w12_busy", 32'(busy12), 0);
        chk("w12_ready_idle", 32'(pix_ready12), 1);

        // FIFO full for 4 cycles while the first pixel's MSB is pending.
        do_reset();
        base = got_q.size();
        fork
            begin
                send_pix(16'h0123, 1'b1, 1'b0);
                send_pix(16'h4567, 1'b0, 1'b0);
                send_pix(16'h89AB, 1'b0, 1'b1);
            end
            begin
                int n;
                n = 0;
                while (got_q.size() < base + 3 && n < 100) begin
                    @(negedge clk);
                    #1 n++;
                end
                chk("wf_hdr_seen", 32'(got_q.size() - base), 3);
                @(posedge clk);
                #1 full_force = 1'b1;
                repeat (4) begin
                    @(negedge clk);
                    chk("wf_winc_low", 32'(tx_winc), 0);
                    chk("wf_wdata_hold", 32'(tx_wdata), 32'h01);
                end
                @(posedge clk);
                #1 full_force = 1'b0;
            end
        join
        wait_idle("wf_idle");
        load_exp(tv_exp[0]);
        cmp_stream("wf", 1'b0, base);
        chk("wf_frame_id", 32'(frame_id), 1);

        // 256 one-pixel frames wrap frame_id back to 0.
        do_reset();
        base = got_q.size();
        for (int f = 0; f < 256; f++) send_pix(16'($urandom), 1'b1, 1'b1);
        wait_idle("wrap_idle");
        run_model();
        cmp_stream("wrap", 1'b0, base);
        chk("wrap_frame_id", 32'(frame_id), 0);
        send_pix(16'h1357, 1'b1, 1'b1);
        wait_idle("wrap_next_idle");
        chk("wrap_next_frame_id", 32'(frame_id), 1);

        // Reset while the MSB byte is being offered.
        send_pix(16'hCAFE, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_busy_before", 32'(busy), 1);
        chk("mid_wdata_before", 32'(tx_wdata), 32'hCA);
        base = got_q.size();
        #1 rst_n = 1'b0;
        #1;
        chk("mid_winc", 32'(tx_winc), 0);
        chk("mid_frame_id", 32'(frame_id), 0);
        chk("mid_busy", 32'(busy), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("mid_no_more_bytes", 32'(got_q.size() - base), 0);

        // Randomized frames, gaps, framing errors and FIFO-full pattern.
        do_reset();
        base = got_q.size();
        rnd_en = 1'b1;
        for (int f = 0; f < 40; f++) begin
            int np;
            np = $urandom_range(1, 4);
            for (int i = 0; i < np; i++) begin
                logic fl, ll;
                fl = (i == 0) ? ($urandom_range(0, 9) != 0) : 1'b0;
                ll = (i == np - 1) ? ($urandom_range(0, 6) != 0) : 1'b0;
                if (f == 39 && i == np - 1) ll = 1'b1;
                send_pix(16'($urandom), fl, ll);
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
        end
        rnd_en = 1'b0;
        wait_idle("rnd_idle");
        run_model();
        cmp_stream("rnd", 1'b0, base);
        chk("rnd_frame_id", 32'(frame_id), 32'(m_fid));
        chk("rnd_err", 32'(err_sticky), 32'(m_err));
        chk("winc_while_full", 32'(viol_full), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
